// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - camera byte-stream frame sequencer, pixel assembler and window
module cam_capture_ctrl #(
    parameter int FrameWidth        = 640,
    parameter int FrameHeight       = 480,
    parameter int ActiveFrameWidth  = 512,
    parameter int ActiveFrameHeight = 384,
    parameter int PixelBitWidth     = 16
) (
    input  logic                                 p_clk,
    input  logic                                 RST,
    input  logic                                 i_cfg_done,
    input  logic                                 i_vsync,
    input  logic                                 i_href,
    input  logic [7:0]                           i_data,
    input  logic                                 i_arm,
    input  logic                                 i_fifo_full,
    output logic [PixelBitWidth-1:0]             o_pixel,
    output logic                                 o_pixel_valid,
    output logic [$clog2(ActiveFrameWidth)-1:0]  o_pixel_x,
    output logic [$clog2(ActiveFrameHeight)-1:0] o_pixel_y,
    output logic                                 o_frame_start,
    output logic                                 o_frame_done,
    output logic                                 o_busy,
    output logic                                 o_overflow,
    output logic                                 o_short_frame
);

    localparam int Xoff = (FrameWidth - ActiveFrameWidth) / 2;
    localparam int Yoff = (FrameHeight - ActiveFrameHeight) / 2;
    localparam int CW   = $clog2(FrameWidth + 1);
    localparam int LW   = $clog2(FrameHeight + 1);
    localparam int XW   = $clog2(ActiveFrameWidth);
    localparam int YW   = $clog2(ActiveFrameHeight);

    localparam logic [CW-1:0] COL_LO    = CW'(Xoff);
    localparam logic [CW-1:0] COL_HI    = CW'(Xoff + ActiveFrameWidth);
    localparam logic [CW-1:0] COL_MAX   = CW'(FrameWidth);
    localparam logic [LW-1:0] LINE_LO   = LW'(Yoff);
    localparam logic [LW-1:0] LINE_HI   = LW'(Yoff + ActiveFrameHeight);
    localparam logic [LW-1:0] LINE_LAST = LW'(FrameHeight - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ARM,
        S_WAIT_VSYNC,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                     cfg_meta_q, cfg_meta_d;
    logic                     cfg_sync_q, cfg_sync_d;
    logic                     vsync_q, vsync_d;
    logic                     href_q, href_d;
    logic [LW-1:0]            line_q, line_d;
    logic [CW-1:0]            col_q, col_d;
    logic                     phase_q, phase_d;
    logic [7:0]               hi_q, hi_d;
    logic [PixelBitWidth-1:0] pixel_q, pixel_d;
    logic                     pixel_valid_q, pixel_valid_d;
    logic [XW-1:0]            pixel_x_q, pixel_x_d;
    logic [YW-1:0]            pixel_y_q, pixel_y_d;
    logic                     frame_start_q, frame_start_d;
    logic                     overflow_q, overflow_d;
    logic                     short_frame_q, short_frame_d;

    logic vsync_rise, vsync_fall, href_fall;
    logic in_capture, start_frame, in_window;
    logic busy, frame_done;

    // Edges compare the registered sample against the live input.
    assign vsync_rise  = ~vsync_q & i_vsync;
    assign vsync_fall  = vsync_q & ~i_vsync;
    assign href_fall   = href_q & ~i_href;
    assign in_capture  = (state_q == S_CAPTURE);
    assign start_frame = (state_q == S_WAIT_VSYNC) & cfg_sync_q & vsync_fall;
    assign in_window   = (col_q >= COL_LO) && (col_q < COL_HI) &&
                         (line_q >= LINE_LO) && (line_q < LINE_HI);

    always_ff @(posedge p_clk) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!cfg_sync_q) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:       state_d = S_WAIT_ARM;
                S_WAIT_ARM:   if (i_arm) state_d = S_WAIT_VSYNC;
                S_WAIT_VSYNC: if (vsync_fall) state_d = S_CAPTURE;
                S_CAPTURE: begin
                    if (vsync_rise || (href_fall && (line_q == LINE_LAST))) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:       state_d = i_arm ? S_WAIT_VSYNC : S_WAIT_ARM;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q == S_WAIT_VSYNC) || (state_q == S_CAPTURE);
        frame_done = (state_q == S_DONE);
    end

    always_comb begin
        cfg_meta_d    = i_cfg_done;
        cfg_sync_d    = cfg_meta_q;
        vsync_d       = i_vsync;
        href_d        = i_href;
        line_d        = line_q;
        col_d         = col_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        pixel_d       = pixel_q;
        pixel_valid_d = 1'b0;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        frame_start_d = start_frame;
        overflow_d    = overflow_q | (pixel_valid_q & i_fifo_full);
        short_frame_d = short_frame_q | (in_capture & vsync_rise & (line_q < LINE_HI));

        if (!in_capture) begin
            line_d  = '0;
            col_d   = '0;
            phase_d = 1'b0;
        end else if (href_fall) begin
            // A dangling odd byte is dropped simply by clearing the phase.
            line_d  = line_q + 1'b1;
            col_d   = '0;
            phase_d = 1'b0;
        end else if (i_href && (col_q != COL_MAX)) begin
            if (!phase_q) begin
                hi_d    = i_data;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                col_d   = col_q + 1'b1;
                if (in_window) begin
                    pixel_valid_d = 1'b1;
                    pixel_d       = PixelBitWidth'({hi_q, i_data});
                    pixel_x_d     = XW'(col_q - COL_LO);
                    pixel_y_d     = YW'(line_q - LINE_LO);
                end
            end
        end

        if (start_frame) begin
            overflow_d    = 1'b0;
            short_frame_d = 1'b0;
        end
    end

    always_ff @(posedge p_clk) begin
        if (!RST) begin
            cfg_meta_q    <= 1'b0;
            cfg_sync_q    <= 1'b0;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            line_q        <= '0;
            col_q         <= '0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_start_q <= 1'b0;
            overflow_q    <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            cfg_meta_q    <= cfg_meta_d;
            cfg_sync_q    <= cfg_sync_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            line_q        <= line_d;
            col_q         <= col_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_start_d;
            overflow_q    <= overflow_d;
            short_frame_q <= short_frame_d;
        end
    end

    assign o_pixel       = pixel_q;
    assign o_pixel_valid = pixel_valid_q;
    assign o_pixel_x     = pixel_x_q;
    assign o_pixel_y     = pixel_y_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_done  = frame_done;
    assign o_busy        = busy;
    assign o_overflow    = overflow_q;
    assign o_short_frame = short_frame_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - randomized self-checking bench for cam_capture_ctrl
module tb_cam_capture_ctrl;

    localparam int FW   = 8;
    localparam int FH   = 6;
    localparam int AW   = 4;
    localparam int AH   = 2;
    localparam int XOFF = (FW - AW) / 2;
    localparam int YOFF = (FH - AH) / 2;
    localparam int XW   = $clog2(AW);
    localparam int YW   = $clog2(AH);

    logic          p_clk;
    logic          rst_n;
    logic          i_cfg_done;
    logic          i_vsync;
    logic          i_href;
    logic [7:0]    i_data;
    logic          i_arm;
    logic          i_fifo_full;
    logic [15:0]   o_pixel;
    logic          o_pixel_valid;
    logic [XW-1:0] o_pixel_x;
    logic [YW-1:0] o_pixel_y;
    logic          o_frame_start;
    logic          o_frame_done;
    logic          o_busy;
    logic          o_overflow;
    logic          o_short_frame;

    cam_capture_ctrl #(
        .FrameWidth       (FW),
        .FrameHeight      (FH),
        .ActiveFrameWidth (AW),
        .ActiveFrameHeight(AH),
        .PixelBitWidth    (16)
    ) dut (
        .p_clk        (p_clk),
        .RST          (rst_n),
        .i_cfg_done   (i_cfg_done),
        .i_vsync      (i_vsync),
        .i_href       (i_href),
        .i_data       (i_data),
        .i_arm        (i_arm),
        .i_fifo_full  (i_fifo_full),
        .o_pixel      (o_pixel),
        .o_pixel_valid(o_pixel_valid),
        .o_pixel_x    (o_pixel_x),
        .o_pixel_y    (o_pixel_y),
        .o_frame_start(o_frame_start),
        .o_frame_done (o_frame_done),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .o_short_frame(o_short_frame)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    typedef struct {
        logic [15:0]   pix;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          ovf;
    } obs_t;

    obs_t obs_q[$];
    obs_t exp_q[$];
    int   n_start;
    int   n_done;
    int   busy_cnt;
    logic ovf_at_start;
    logic short_at_start;

    logic [7:0] data_mem[FH][32];
    int         line_len[FH];
    logic       pending_full;
    int         n_pass;
    int         n_total;

    initial begin
        n_start = 0;
        n_done = 0;
        busy_cnt = 0;
        ovf_at_start = 1'b0;
        short_at_start = 1'b0;
    end

    always @(negedge p_clk) begin
        if (o_pixel_valid) obs_q.push_back('{o_pixel, o_pixel_x, o_pixel_y, o_overflow});
        if (o_frame_start) begin
            n_start++;
            ovf_at_start = o_overflow;
            short_at_start = o_short_frame;
        end
        if (o_frame_done) n_done++;
        if (o_busy) busy_cnt++;
    end

    task automatic tick(input logic href, input logic [7:0] d);
        i_fifo_full = pending_full;
        pending_full = 1'b0;
        i_href = href;
        i_data = d;
        @(posedge p_clk);
        #1;
    endtask

    task automatic fill_pattern();
        for (int l = 0; l < FH; l++) begin
            line_len[l] = 2 * FW;
            for (int n = 0; n < 32; n++) data_mem[l][n] = 8'(l * 16 + n);
        end
    endtask

    task automatic fill_random();
        for (int l = 0; l < FH; l++) begin
            line_len[l] = int'($urandom_range(12, 20));
            for (int n = 0; n < 32; n++) data_mem[l][n] = 8'($urandom);
        end
    endtask

    // Reference: every completed byte pair inside the centred window, first byte high.
    task automatic build_expected(input int nlines);
        int np;
        exp_q.delete();
        for (int l = 0; l < nlines; l++) begin
            np = line_len[l] / 2;
            if (np > FW) np = FW;
            for (int p = 0; p < np; p++) begin
                if (p >= XOFF && p < XOFF + AW && l >= YOFF && l < YOFF + AH)
                    exp_q.push_back('{{data_mem[l][2*p], data_mem[l][2*p+1]},
                                      XW'(p - XOFF), YW'(l - YOFF), 1'b0});
            end
        end
    endtask

    task automatic drive_frame(input int nlines, input int full_idx, input int arm_drop_line,
                               input bit tail_vs);
        int k;
        i_vsync = 1'b1;
        repeat (3) tick(1'b0, 8'h00);
        i_vsync = 1'b0;
        repeat ($urandom_range(1, 3)) tick(1'b0, 8'h00);
        k = 0;
        for (int l = 0; l < nlines; l++) begin
            if (l == arm_drop_line) i_arm = 1'b0;
            for (int n = 0; n < line_len[l]; n++) begin
                tick(1'b1, data_mem[l][n]);
                if ((n % 2 == 1) && (n / 2 < FW) && (n / 2 >= XOFF) && (n / 2 < XOFF + AW) &&
                    (l >= YOFF) && (l < YOFF + AH)) begin
                    if (k == full_idx) pending_full = 1'b1;
                    k++;
                end
            end
            repeat ($urandom_range(1, 3)) tick(1'b0, 8'h00);
        end
        repeat (4) tick(1'b0, 8'h00);
        if (tail_vs) begin
            i_vsync = 1'b1;
            repeat (3) tick(1'b0, 8'h00);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick(1'b0, 8'h00);
        n_total++;
        if ({o_pixel, o_pixel_valid, o_pixel_x, o_pixel_y, o_frame_start, o_frame_done,
             o_busy, o_overflow, o_short_frame} !== '0)
            $display("FAIL reset_outputs: got pix=%h v=%b start=%b done=%b busy=%b ovf=%b short=%b, want all 0",
                     o_pixel, o_pixel_valid, o_frame_start, o_frame_done, o_busy, o_overflow, o_short_frame);
        else n_pass++;
        rst_n = 1'b1;
        i_cfg_done = 1'b1;
        i_arm = 1'b1;
        repeat (6) tick(1'b0, 8'h00);
        n_total++;
        if (o_busy !== 1'b1) $display("FAIL reset_to_wait_vsync: busy=%b want 1", o_busy);
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        int base, s0, d0, got;
        fill_pattern();
        build_expected(FH);
        base = obs_q.size();
        s0 = n_start;
        d0 = n_done;
        drive_frame(FH, -1, -1, 1'b0);
        got = obs_q.size() - base;
        n_total++;
        if (got !== 8) $display("FAIL basic_count: got %0d valids, want 8", got);
        else n_pass++;
        n_total++;
        if (n_done - d0 !== 1) $display("FAIL basic_done_on_href: got %0d done pulses, want 1", n_done - d0);
        else n_pass++;
        n_total++;
        if (n_start - s0 !== 1) $display("FAIL basic_start: got %0d start pulses, want 1", n_start - s0);
        else n_pass++;
        if (got >= 8) begin
            n_total++;
            if ({obs_q[base].pix, obs_q[base].x, obs_q[base].y} !== {16'h2425, 2'd0, 1'd0})
                $display("FAIL basic_first: got pix=%h x=%0d y=%0d, want 2425 0 0",
                         obs_q[base].pix, obs_q[base].x, obs_q[base].y);
            else n_pass++;
            n_total++;
            if ({obs_q[base+7].pix, obs_q[base+7].x, obs_q[base+7].y} !== {16'h3A3B, 2'd3, 1'd1})
                $display("FAIL basic_last: got pix=%h x=%0d y=%0d, want 3a3b 3 1",
                         obs_q[base+7].pix, obs_q[base+7].x, obs_q[base+7].y);
            else n_pass++;
        end
        i_vsync = 1'b1;
        repeat (3) tick(1'b0, 8'h00);
        n_total++;
        if (n_done - d0 !== 1) $display("FAIL basic_no_extra_done: got %0d, want 1", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_random_frames();
        int base, got, n;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            build_expected(FH);
            base = obs_q.size();
            drive_frame(FH, -1, -1, 1'b1);
            got = obs_q.size() - base;
            n_total++;
            if (got !== exp_q.size())
                $display("FAIL rand_count f%0d: got %0d, want %0d", f, got, exp_q.size());
            else n_pass++;
            n = (got < exp_q.size()) ? got : exp_q.size();
            for (int i = 0; i < n; i++) begin
                n_total++;
                if ({obs_q[base+i].pix, obs_q[base+i].x, obs_q[base+i].y} !==
                    {exp_q[i].pix, exp_q[i].x, exp_q[i].y})
                    $display("FAIL rand_pixel f%0d #%0d: got %h/%0d/%0d, want %h/%0d/%0d", f, i,
                             obs_q[base+i].pix, obs_q[base+i].x, obs_q[base+i].y,
                             exp_q[i].pix, exp_q[i].x, exp_q[i].y);
                else n_pass++;
            end
        end
    endtask

    task automatic test_overflow();
        int base, got;
        fill_pattern();
        base = obs_q.size();
        drive_frame(FH, 2, -1, 1'b1);
        got = obs_q.size() - base;
        n_total++;
        if (got !== 8) $display("FAIL ovf_count: got %0d valids, want 8", got);
        else n_pass++;
        if (got >= 4) begin
            n_total++;
            if (obs_q[base+2].ovf !== 1'b0) $display("FAIL ovf_before: got %b at 3rd valid, want 0", obs_q[base+2].ovf);
            else n_pass++;
            n_total++;
            if (obs_q[base+3].ovf !== 1'b1) $display("FAIL ovf_after: got %b at 4th valid, want 1", obs_q[base+3].ovf);
            else n_pass++;
        end
        n_total++;
        if (o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, want 1", o_overflow);
        else n_pass++;
        drive_frame(FH, -1, -1, 1'b1);
        n_total++;
        if (ovf_at_start !== 1'b0) $display("FAIL ovf_clear_at_start: got %b, want 0", ovf_at_start);
        else n_pass++;
    endtask

    task automatic test_short_frame();
        int base, d0, got;
        fill_pattern();
        build_expected(3);
        base = obs_q.size();
        d0 = n_done;
        drive_frame(3, -1, -1, 1'b1);
        got = obs_q.size() - base;
        n_total++;
        if (got !== exp_q.size() || got !== 4) $display("FAIL short_count: got %0d, want 4", got);
        else n_pass++;
        n_total++;
        if (n_done - d0 !== 1) $display("FAIL short_done: got %0d done pulses, want 1", n_done - d0);
        else n_pass++;
        n_total++;
        if (o_short_frame !== 1'b1) $display("FAIL short_flag: got %b, want 1", o_short_frame);
        else n_pass++;
    endtask

    task automatic test_arm_two_frames();
        int base, s0, d0, got;
        s0 = n_start;
        d0 = n_done;
        fill_random();
        build_expected(FH);
        base = obs_q.size();
        drive_frame(FH, -1, -1, 1'b1);
        got = obs_q.size() - base;
        n_total++;
        if (short_at_start !== 1'b0) $display("FAIL short_clear_at_start: got %b, want 0", short_at_start);
        else n_pass++;
        n_total++;
        if (got !== exp_q.size()) $display("FAIL two_f1_count: got %0d, want %0d", got, exp_q.size());
        else n_pass++;
        fill_random();
        build_expected(FH);
        base = obs_q.size();
        drive_frame(FH, -1, 3, 1'b1);
        got = obs_q.size() - base;
        n_total++;
        if (got !== exp_q.size()) $display("FAIL two_f2_count: got %0d, want %0d", got, exp_q.size());
        else n_pass++;
        if (got > 0 && exp_q.size() > 0) begin
            n_total++;
            if ({obs_q[base].pix, obs_q[base].x, obs_q[base].y} !== {exp_q[0].pix, exp_q[0].x, 1'd0})
                $display("FAIL two_f2_first: got %h/%0d/%0d, want %h/%0d/0", obs_q[base].pix,
                         obs_q[base].x, obs_q[base].y, exp_q[0].pix, exp_q[0].x);
            else n_pass++;
        end
        n_total++;
        if ((n_start - s0 !== 2) || (n_done - d0 !== 2))
            $display("FAIL two_pairs: got %0d starts %0d dones, want 2 2", n_start - s0, n_done - d0);
        else n_pass++;
        n_total++;
        if (o_busy !== 1'b0) $display("FAIL two_wait_arm_busy: got %b, want 0", o_busy);
        else n_pass++;
        s0 = n_start;
        i_vsync = 1'b0;
        repeat (4) tick(1'b0, 8'h00);
        n_total++;
        if (n_start - s0 !== 0) $display("FAIL two_unarmed_start: got %0d starts, want 0", n_start - s0);
        else n_pass++;
        i_vsync = 1'b1;
        i_arm = 1'b1;
        repeat (3) tick(1'b0, 8'h00);
    endtask

    task automatic test_cfg_gate();
        int base, s0, b0, got;
        i_cfg_done = 1'b0;
        repeat (4) tick(1'b0, 8'h00);
        fill_pattern();
        base = obs_q.size();
        s0 = n_start;
        b0 = busy_cnt;
        drive_frame(FH, -1, -1, 1'b1);
        n_total++;
        if ((obs_q.size() - base !== 0) || (n_start - s0 !== 0) || (busy_cnt - b0 !== 0))
            $display("FAIL cfg_gate: got %0d valids %0d starts %0d busy cycles, want 0 0 0",
                     obs_q.size() - base, n_start - s0, busy_cnt - b0);
        else n_pass++;
        i_cfg_done = 1'b1;
        repeat (3) tick(1'b0, 8'h00);
        n_total++;
        if (o_busy !== 1'b0) $display("FAIL cfg_latency_early: busy=%b after 3 edges, want 0", o_busy);
        else n_pass++;
        tick(1'b0, 8'h00);
        n_total++;
        if (o_busy !== 1'b1) $display("FAIL cfg_latency_ready: busy=%b after 4 edges, want 1", o_busy);
        else n_pass++;
        base = obs_q.size();
        drive_frame(FH, -1, -1, 1'b1);
        got = obs_q.size() - base;
        n_total++;
        if (got !== 8) $display("FAIL cfg_resume_count: got %0d, want 8", got);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int base, d0, got;
        fill_pattern();
        base = obs_q.size();
        d0 = n_done;
        i_vsync = 1'b1;
        repeat (3) tick(1'b0, 8'h00);
        i_vsync = 1'b0;
        repeat (2) tick(1'b0, 8'h00);
        for (int l = 0; l < 2; l++) begin
            for (int n = 0; n < 16; n++) tick(1'b1, data_mem[l][n]);
            repeat (2) tick(1'b0, 8'h00);
        end
        for (int n = 0; n < 8; n++) tick(1'b1, data_mem[2][n]);
        rst_n = 1'b0;
        tick(1'b1, data_mem[2][8]);
        n_total++;
        if ({o_pixel, o_pixel_valid, o_pixel_x, o_pixel_y, o_frame_start, o_frame_done,
             o_busy, o_overflow, o_short_frame} !== '0)
            $display("FAIL midreset_outputs: got pix=%h v=%b done=%b busy=%b, want all 0",
                     o_pixel, o_pixel_valid, o_frame_done, o_busy);
        else n_pass++;
        rst_n = 1'b1;
        for (int n = 9; n < 16; n++) tick(1'b1, data_mem[2][n]);
        for (int l = 3; l < FH; l++) begin
            repeat (2) tick(1'b0, 8'h00);
            for (int n = 0; n < 16; n++) tick(1'b1, data_mem[l][n]);
        end
        repeat (4) tick(1'b0, 8'h00);
        got = obs_q.size() - base;
        n_total++;
        if (got !== 2) $display("FAIL midreset_valids: got %0d, want 2", got);
        else n_pass++;
        n_total++;
        if (n_done - d0 !== 0) $display("FAIL midreset_no_done: got %0d, want 0", n_done - d0);
        else n_pass++;
        base = obs_q.size();
        drive_frame(FH, -1, -1, 1'b1);
        got = obs_q.size() - base;
        n_total++;
        if (got !== 8) $display("FAIL midreset_resume: got %0d, want 8", got);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        pending_full = 1'b0;
        rst_n = 1'b0;
        i_cfg_done = 1'b0;
        i_vsync = 1'b0;
        i_href = 1'b0;
        i_data = 8'h00;
        i_arm = 1'b0;
        i_fifo_full = 1'b0;
        #1;
        test_reset();
        test_basic_frame();
        test_random_frames();
        test_overflow();
        test_short_frame();
        test_arm_two_frames();
        test_cfg_gate();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- p_clk-domain sequencer for the OV-series camera byte stream.
- Waits for SCCB configuration to finish, then arms on request and aligns to the VSYNC frame boundary.
- Tracks line and column position, assembles byte pairs into 16-bit Y+U/V pixels (MSB first), and windows the centred active region.
- Emits a valid/position stream with frame-start and frame-done markers, and flags downstream backpressure drops and short frames.

Parameters:
- FrameWidth, 640, total pixels per HREF line.
- FrameHeight, 480, total HREF lines per frame.
- ActiveFrameWidth, 512, windowed pixels per line; must be even and ≤ FrameWidth.
- ActiveFrameHeight, 384, windowed lines per frame; must be ≤ FrameHeight.
- PixelBitWidth, 16, output pixel width; fixed at 2 bytes.

Ports:
- p_clk  in  1  pixel clock from camera.
- RST  in  1  synchronous, active-low reset.
- i_cfg_done  in  1  SCCB setup complete; from the CLK domain, 2-flop synchronised internally.
- i_vsync  in  1  camera VSYNC, high = vertical blank.
- i_href  in  1  camera HREF, high = byte valid.
- i_data  in  8  camera data byte.
- i_arm  in  1  level; capture frames while high.
- i_fifo_full  in  1  downstream cannot accept a pixel.
- o_pixel  out  16  assembled pixel; first byte in [15:8].
- o_pixel_valid  out  1  one-cycle strobe for an in-window pixel.
- o_pixel_x  out  $clog2(ActiveFrameWidth)  window column of o_pixel.
- o_pixel_y  out  $clog2(ActiveFrameHeight)  window row of o_pixel.
- o_frame_start  out  1  one-cycle pulse on the first captured cycle of a frame.
- o_frame_done  out  1  one-cycle pulse at the end of a frame.
- o_busy  out  1  high in WAIT_VSYNC and CAPTURE.
- o_overflow  out  1  sticky; a valid pixel coincided with i_fifo_full.
- o_short_frame  out  1  sticky; VSYNC arrived before ActiveFrameHeight lines completed.

Behaviour:
- Reset (RST=0 at p_clk edge): state=IDLE; all outputs 0; counters, byte phase, sync flops and edge registers cleared. Reset mid-frame aborts immediately with no o_frame_done.
- Edge detection: i_vsync and i_href are registered once. Rise/fall are derived from the registered value vs the current input.
- cfg_sync is the second synchroniser flop of i_cfg_done.

State machine:
- IDLE: go to WAIT_ARM when cfg_sync=1.
- WAIT_ARM: go to WAIT_VSYNC when i_arm=1.
- WAIT_VSYNC: on a VSYNC falling edge, go to CAPTURE and pulse o_frame_start in the same cycle. Clear line/col/phase counters and both sticky flags.
- CAPTURE: capture per the rules below.
  - Go to DONE on a VSYNC rising edge, or on the HREF falling edge that completes line FrameHeight-1.
  - If a VSYNC rising edge arrives with line count < ActiveFrameHeight+Yoff, set o_short_frame.
- DONE: pulse o_frame_done for one cycle. Go to WAIT_VSYNC if i_arm=1, otherwise to WAIT_ARM.
- In any state, cfg_sync=0 forces IDLE next cycle, with no frame_done.
- Dropping i_arm during CAPTURE does not abort; the frame completes.

Capture rules (CAPTURE state only):
- Xoff = (FrameWidth-ActiveFrameWidth)/2; Yoff = (FrameHeight-ActiveFrameHeight)/2.
- While i_href=1, each cycle samples one byte:
  - phase 0: byte stored to hi.
  - phase 1: {hi, byte} forms the pixel and col increments.
- On HREF falling edge: line increments and col/phase clear. A line ending on an odd byte discards the dangling byte.
- Pixel is in-window iff Xoff ≤ col < Xoff+ActiveFrameWidth and Yoff ≤ line < Yoff+ActiveFrameHeight.
- For an in-window pixel, o_pixel_valid=1 in the cycle after the phase-1 byte, with o_pixel_x=col-Xoff and o_pixel_y=line-Yoff. o_pixel holds its value until the next valid.
- Out-of-window pixels produce no strobe. col saturates at FrameWidth (extra bytes are ignored).
- o_pixel_valid is still asserted when i_fifo_full=1 (no stall; the pixel is lost). In that case set o_overflow, which clears only at the next frame start or reset.

Test Plan:
- Params FrameWidth=8, FrameHeight=6, Active=4x2 (Xoff=2, Yoff=2); cfg_done=1, arm=1; 6 lines of 16 bytes, byte n = line*16+n → exactly 8 valids. First valid: pixel=16'h2425, x=0, y=0. Last valid: pixel=16'h3A3B, x=3, y=1. One o_frame_start, then one o_frame_done after line 5 HREF fall.
- cfg_done=0 while arm=1 and frames run → no valids, o_busy=0. Raise cfg_done → capture begins only at the next VSYNC fall, after the 2-cycle sync latency.
- Same stimulus with i_fifo_full=1 during the 3rd valid → all 8 strobes still occur and o_overflow=1 after the 3rd valid. o_overflow=0 at the next frame start.
- VSYNC rises after line 2 (only 1 active line done) → o_frame_done pulse, o_short_frame=1, 4 valids seen.
- arm=1 for two frames → two start/done pairs, counters restart (first valid y=0 again). Deassert arm mid-frame 2 → frame 2 completes, then state WAIT_ARM with o_busy=0.
- RST=0 mid-line of CAPTURE → next cycle all outputs 0, no frame_done. After release with cfg_done=1, no capture until the next VSYNC fall.
